// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the two-digit calculator display scanner.
package calc_disp_pkg;

  typedef enum logic [1:0] {
    S_UNITS = 2'd0,
    S_GAP0  = 2'd1,
    S_TENS  = 2'd2,
    S_GAP1  = 2'd3
  } scan_state_e;

  // Active-low segment patterns
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic signed [5:0] VAL_MIN  = -6'sd9;
  localparam logic signed [5:0] VAL_MAX  = 6'sd18;
  localparam logic signed [5:0] TENS_MIN = 6'sd10;

  localparam logic [2:0] AN_UNITS = 3'd0;
  localparam logic [2:0] AN_TENS  = 3'd4;

  function automatic logic in_range(input logic signed [5:0] v);
    return (v >= VAL_MIN) && (v <= VAL_MAX);
  endfunction

  function automatic logic [7:0] anode_on(input logic [2:0] idx);
    logic [7:0] a;
    a      = 8'hFF;
    a[idx] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Scan-slot divider: counts 0..REFRESH_DIV-1 and flags the last count.
module disp_tick_gen #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (cnt_q == TERM) cnt_d = '0;
    else               cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == TERM);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed two-digit display scanner for a signed calculator result.
// state   | meaning
// S_UNITS | units digit anode active, decoder drives segments
// S_GAP0  | all anodes off between digits
// S_TENS  | sign/tens anode active (minus, one, or blank)
// S_GAP1  | all anodes off; leaving it closes the frame
module disp_scan_ctrl
  import calc_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] value,
  output logic [5:0] dig_code,
  output logic       ovr_en,
  output logic [6:0] ovr_seg,
  output logic [7:0] an,
  output logic       err
);

  logic tick;

  disp_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  scan_state_e state_q, state_d;

  logic signed [5:0] shown_q, shown_d;
  logic signed [5:0] pend_val_q, pend_val_d;
  logic              pend_vld_q, pend_vld_d;
  logic              frame_end;

  logic [7:0]        an_q, an_d;
  logic signed [5:0] dig_q, dig_d;
  logic              ovr_en_q, ovr_en_d;
  logic [6:0]        ovr_seg_q, ovr_seg_d;
  logic              err_q, err_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_UNITS;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_UNITS: state_d = S_GAP0;
        S_GAP0:  state_d = S_TENS;
        S_TENS:  state_d = S_GAP1;
        S_GAP1:  state_d = S_UNITS;
        default: state_d = S_UNITS;
      endcase
    end
  end

  assign frame_end = tick && (state_q == S_GAP1);

  // A load landing on the frame boundary bypasses the pending register
  always_comb begin
    shown_d    = shown_q;
    pend_val_d = pend_val_q;
    pend_vld_d = pend_vld_q;
    if (frame_end) begin
      if (load) begin
        shown_d = $signed(value);
      end else if (pend_vld_q) begin
        shown_d = pend_val_q;
      end
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_val_d = $signed(value);
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shown_q    <= '0;
      pend_val_q <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      shown_q    <= shown_d;
      pend_val_q <= pend_val_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  // Output logic
  always_comb begin
    an_d      = 8'hFF;
    ovr_en_d  = 1'b0;
    ovr_seg_d = SEG_BLANK;
    dig_d     = dig_q;
    err_d     = !in_range(shown_q);
    case (state_q)
      S_UNITS: begin
        an_d = anode_on(AN_UNITS);
        if (err_d) begin
          ovr_en_d  = 1'b1;
          ovr_seg_d = SEG_MINUS;
        end else begin
          dig_d = shown_q;
        end
      end
      S_TENS: begin
        if (err_d || shown_q[5]) begin
          an_d      = anode_on(AN_TENS);
          ovr_en_d  = 1'b1;
          ovr_seg_d = SEG_MINUS;
        end else if (shown_q >= TENS_MIN) begin
          an_d      = anode_on(AN_TENS);
          ovr_en_d  = 1'b1;
          ovr_seg_d = SEG_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q      <= 8'hFF;
      dig_q     <= '0;
      ovr_en_q  <= 1'b0;
      ovr_seg_q <= SEG_BLANK;
      err_q     <= 1'b0;
    end else begin
      an_q      <= an_d;
      dig_q     <= dig_d;
      ovr_en_q  <= ovr_en_d;
      ovr_seg_q <= ovr_seg_d;
      err_q     <= err_d;
    end
  end

  assign an       = an_q;
  assign dig_code = dig_q;
  assign ovr_en   = ovr_en_q;
  assign ovr_seg  = ovr_seg_q;
  assign err      = err_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed scenarios plus random loads/resets vs a slot-arithmetic model.
module tb_disp_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk;
  logic       rst;
  logic       load;
  logic [5:0] value;
  logic [5:0] dig_code;
  logic       ovr_en;
  logic [6:0] ovr_seg;
  logic [7:0] an;
  logic       err;

  disp_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .dig_code (dig_code),
    .ovr_en   (ovr_en),
    .ovr_seg  (ovr_seg),
    .an       (an),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: time since reset in cycles, display value and pending load
  int   m_k;
  int   m_shown;
  bit   m_pend;
  int   m_pv;
  logic [7:0] e_an;
  logic [5:0] e_dig;
  logic       e_en;
  logic [6:0] e_seg;
  logic       e_err;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic model_edge(input logic ld, input int v, input logic r);
    int  slot;
    bit  bad;
    bit  boundary;
    if (r) begin
      m_k = 0; m_shown = 0; m_pend = 0; m_pv = 0;
      e_an = 8'hFF; e_dig = 6'd0; e_en = 1'b0; e_seg = 7'h7F; e_err = 1'b0;
      return;
    end
    slot = (m_k / DIV) % 4;
    bad  = (m_shown < -9) || (m_shown > 18);
    e_err = bad;
    e_an  = 8'hFF;
    e_en  = 1'b0;
    e_seg = 7'h7F;
    if (slot == 0) begin
      e_an = 8'hFE;
      if (bad) begin e_en = 1'b1; e_seg = 7'b0111111; end
      else e_dig = m_shown[5:0];
    end else if (slot == 2) begin
      if (bad || m_shown < 0) begin e_an = 8'hEF; e_en = 1'b1; e_seg = 7'b0111111; end
      else if (m_shown >= 10) begin e_an = 8'hEF; e_en = 1'b1; e_seg = 7'b1111001; end
    end
    boundary = (slot == 3) && ((m_k % DIV) == DIV - 1);
    if (boundary) begin
      if (ld) m_shown = v;
      else if (m_pend) m_shown = m_pv;
      m_pend = 0;
    end else if (ld) begin
      m_pend = 1; m_pv = v;
    end
    m_k++;
  endtask

  task automatic step(input logic ld, input int v, input logic r);
    logic [5:0] vb;
    vb    = v[5:0];
    rst   = r;
    load  = ld;
    value = vb;
    @(posedge clk);
    model_edge(ld, $signed(vb), r);
    #1;
    chk("an", an, e_an);
    chk("dig_code", {2'b00, dig_code}, {2'b00, e_dig});
    chk("ovr_en", {7'd0, ovr_en}, {7'd0, e_en});
    chk("err", {7'd0, err}, {7'd0, e_err});
    if (e_en) chk("ovr_seg", {1'b0, ovr_seg}, {1'b0, e_seg});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  // Advance until the model reaches the given position within the frame
  task automatic wait_frame_pos(input int pos);
    int guard;
    guard = 0;
    while ((m_k % FRAME) != pos && guard < 4 * FRAME) begin
      step(1'b0, 0, 1'b0);
      guard++;
    end
    n_vec++;
    if (guard >= 4 * FRAME) begin
      n_fail++;
      $display("FAIL wait_frame_pos: position %0d not reached", pos);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = 6'd0;
    // Reset state, load during reset is discarded
    step(1'b0, 0, 1'b1);
    step(1'b1, 5, 1'b1);
    step(1'b0, 0, 1'b1);
    idle(2 * FRAME);

    step(1'b1, -5, 1'b0);
    idle(2 * FRAME + 3);

    step(1'b1, 14, 1'b0);
    idle(2 * FRAME + 5);

    wait_frame_pos(1);
    step(1'b1, 3, 1'b0);
    idle(2);
    step(1'b1, 7, 1'b0);
    idle(2 * FRAME);

    step(1'b1, 25, 1'b0);
    idle(2 * FRAME);
    step(1'b1, 0, 1'b0);
    idle(2 * FRAME);

    // Load coincident with the boundary tick
    wait_frame_pos(FRAME - 1);
    step(1'b1, 9, 1'b0);
    idle(FRAME);
    wait_frame_pos(FRAME - 1);
    step(1'b1, -9, 1'b0);
    idle(FRAME + 2);
    step(1'b1, 18, 1'b0);
    idle(2 * FRAME);
    step(1'b1, -10, 1'b0);
    idle(2 * FRAME);

    // Reset during S_TENS with -2 displayed
    step(1'b1, -2, 1'b0);
    wait_frame_pos(0);
    wait_frame_pos(2 * DIV + 1);
    step(1'b0, 0, 1'b1);
    idle(FRAME + 3);

    for (int i = 0; i < 3000; i++) begin
      logic ld;
      logic r;
      int   v;
      ld = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 399) == 0);
      v  = int'($urandom_range(0, 37)) - 12;
      step(ld, v, r);
    end
    idle(2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per scan slot (at least 2).
REQ-002 clk  input  1  single system clock; all logic on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 load  input  1  one-cycle strobe; value is sampled when load=1.
REQ-005 value  input  6  signed two's-complement calculator result; legal range -9..18.
REQ-006 dig_code  output  6  signed code for the units digit, fed to the downstream seven_seg decoder input.
REQ-007 ovr_en  output  1  when 1, segment lines take ovr_seg instead of the decoder output.
REQ-008 ovr_seg  output  7  active-low override segment pattern.
REQ-009 an  output  8  active-low anode enables; only an[0] (units) and an[4] (sign/tens) are ever driven low.
REQ-010 err  output  1  high while the displayed value is out of range.

Function
REQ-011 Divider counts 0..REFRESH_DIV-1 and wraps; tick = 1 for one cycle when the count equals REFRESH_DIV-1.
REQ-012 FSM states S_UNITS -> S_GAP0 -> S_TENS -> S_GAP1 -> S_UNITS, advancing only on tick.
REQ-013 Frame boundary = the S_GAP1 -> S_UNITS transition.
REQ-014 load stores value into a pending register and sets a pending flag; the last load before a boundary wins.
REQ-015 At the frame boundary, if pending=1, shown <= pending value and pending clears; shown never changes mid-frame.
REQ-016 load in the same cycle as the boundary tick: the new value becomes shown at that boundary.
REQ-017 All outputs are registered and reflect the FSM state with 1 cycle of latency.
REQ-018 S_UNITS, in range: an=8'hFE, dig_code=shown, ovr_en=0.
REQ-019 S_TENS, shown<0: an=8'hEF, ovr_en=1, ovr_seg=7'b0111111 (minus).
REQ-020 S_TENS, 10<=shown<=18: an=8'hEF, ovr_en=1, ovr_seg=7'b1111001 (one).
REQ-021 S_TENS, 0<=shown<=9: an=8'hFF (leading blank), ovr_en=0.
REQ-022 S_GAP0/S_GAP1: an=8'hFF, ovr_en=0 (ghosting guard).
REQ-023 shown<-9 or shown>18: err=1; in S_UNITS and S_TENS the active anode is driven with ovr_en=1 and ovr_seg=7'b0111111 (dash-dash).
REQ-024 dig_code holds its last value outside S_UNITS.

Reset
REQ-025 rst=1 sets: divider=0, state=S_UNITS, shown=0, pending=0, pending flag=0.
REQ-026 rst=1 sets outputs: an=8'hFF, dig_code=0, ovr_en=0, ovr_seg=7'h7F, err=0.
REQ-027 A load coincident with rst is discarded.
REQ-028 rst mid-frame aborts the frame; the first cycle after release drives S_UNITS outputs for value 0 (an=8'hFE, dig_code=0).

Structure
REQ-029 Package calc_disp_pkg holds the FSM state enum, SEG_MINUS, SEG_ONE, SEG_BLANK (7'h7F), VAL_MIN=-9, VAL_MAX=18, and the anode index constants 0 and 4.
REQ-030 The divider is one sub-module, disp_tick_gen (parameter REFRESH_DIV; ports clk, rst, tick).
REQ-031 The seven_seg decoder is instantiated by the parent, not inside this block.

Verification (all scenarios use REFRESH_DIV=4)
REQ-032 Reset, then no load -> an cycles FE,FF,FF,FF each for 4 clk; dig_code=0; err=0.
REQ-033 load value=-5 -> from the next frame: S_UNITS dig_code=-5 (6'h3B); S_TENS an=EF, ovr_seg=7'b0111111.
REQ-034 load 14 -> S_UNITS dig_code=14; S_TENS an=EF, ovr_en=1, ovr_seg=7'b1111001.
REQ-035 load 3, then load 7 in the same frame -> next frame shows 7 only; 3 never appears on dig_code.
REQ-036 load 25 -> err=1; both active slots show ovr_seg=7'b0111111; a subsequent load 0 clears err at the next boundary.
REQ-037 Assert rst during S_TENS with value=-2 shown -> on release an=FE, dig_code=0, ovr_en=0, no minus shown.
